// File: rtl/echo_request_arbiter.sv
// -----------------------------------------------------------------------------
// echo_request_arbiter
//
// Shares one downstream "echo" say/heard channel between two clients.
// Say requests are arbitrated round-robin and forwarded with zero latency.
// The id of each forwarded client is pushed into a small tag FIFO. Heard
// responses from downstream are routed back to the client at the FIFO head,
// strictly in issue order.
//
// Ports
//   CLK              : clock, all state changes on the rising edge
//   nRST             : asynchronous active-low reset
//   req_say__ENA[1:0]: per-client say enable (bit i = client i)
//   req_say_meth/v   : per-client payload, client i at [32i+31:32i]
//   req_say__RDY[1:0]: per-client say ready
//   ind_heard__ENA   : per-client heard enable (only the head client's bit)
//   ind_heard_meth/v : heard payload, broadcast to both clients
//   ind_heard__RDY   : per-client heard ready
//   echo_say__ENA    : downstream say enable
//   echo_say_meth/v  : downstream say payload
//   echo_say__RDY    : downstream say ready
//   echo_heard__ENA  : downstream heard enable
//   echo_heard_meth/v: downstream heard payload
//   echo_heard__RDY  : downstream heard ready
// -----------------------------------------------------------------------------
module echo_request_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [1:0]  req_say__ENA,
    input  logic [63:0] req_say_meth,
    input  logic [63:0] req_say_v,
    output logic [1:0]  req_say__RDY,
    output logic [1:0]  ind_heard__ENA,
    output logic [31:0] ind_heard_meth,
    output logic [31:0] ind_heard_v,
    input  logic [1:0]  ind_heard__RDY,
    output logic        echo_say__ENA,
    output logic [31:0] echo_say_meth,
    output logic [31:0] echo_say_v,
    input  logic        echo_say__RDY,
    input  logic        echo_heard__ENA,
    input  logic [31:0] echo_heard_meth,
    input  logic [31:0] echo_heard_v,
    output logic        echo_heard__RDY
);

    localparam int          AW     = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

    logic             r_prio;
    logic [AW:0]      r_count;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [DEPTH-1:0] r_tags;

    logic       w_down_ok;
    logic [1:0] w_rdy;
    logic [1:0] w_fire;
    logic       w_push;
    logic       w_push_tag;
    logic       w_sel;
    logic       w_head;
    logic       w_heard_rdy;
    logic       w_pop;

    assign w_down_ok   = echo_say__RDY & (r_count != C_FULL);
    assign w_fire      = req_say__ENA & w_rdy;
    assign w_push      = w_fire[0] | w_fire[1];
    assign w_push_tag  = w_fire[1];
    assign w_head      = r_tags[r_rd_ptr];
    assign w_heard_rdy = (r_count != {(AW + 1){1'b0}}) & ind_heard__RDY[w_head];
    assign w_pop       = echo_heard__ENA & w_heard_rdy;

    // Round-robin grant: the priority client wins, the other only when prio is idle.
    always_comb begin
        w_rdy    = 2'b00;
        w_rdy[0] = w_down_ok & (~r_prio | ~req_say__ENA[r_prio]);
        w_rdy[1] = w_down_ok & ( r_prio | ~req_say__ENA[r_prio]);
    end

    // Payload source: the firing client, or the priority client when idle.
    always_comb begin
        w_sel = r_prio;
        if (w_fire[1]) begin
            w_sel = 1'b1;
        end else if (w_fire[0]) begin
            w_sel = 1'b0;
        end else begin
            w_sel = r_prio;
        end
    end

    // Downstream say mux.
    always_comb begin
        echo_say_meth = req_say_meth[31:0];
        echo_say_v    = req_say_v[31:0];
        if (w_sel) begin
            echo_say_meth = req_say_meth[63:32];
            echo_say_v    = req_say_v[63:32];
        end else begin
            echo_say_meth = req_say_meth[31:0];
            echo_say_v    = req_say_v[31:0];
        end
    end

    // Heard routing: only the client at the FIFO head sees the enable.
    always_comb begin
        ind_heard__ENA = 2'b00;
        if (w_pop) begin
            ind_heard__ENA = w_head ? 2'b10 : 2'b01;
        end else begin
            ind_heard__ENA = 2'b00;
        end
    end

    assign req_say__RDY    = w_rdy;
    assign echo_say__ENA   = w_push;
    assign echo_heard__RDY = w_heard_rdy;
    assign ind_heard_meth  = echo_heard_meth;
    assign ind_heard_v     = echo_heard_v;

    // Priority, pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW).
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_prio   <= 1'b0;
            r_count  <= {(AW + 1){1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
        end else begin
            if (w_push) begin
                r_prio   <= ~w_push_tag;
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage; stale entries are harmless because occupancy gates every read.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_tags[r_wr_ptr] <= w_push_tag;
        end
    end

endmodule

// File: tb/tb_echo_request_arbiter.sv
module tb_echo_request_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  say_ena;
    logic [63:0] say_meth;
    logic [63:0] say_v;
    logic [1:0]  say_rdy;
    logic [1:0]  ind_ena;
    logic [31:0] ind_meth;
    logic [31:0] ind_v;
    logic [1:0]  ind_rdy;
    logic        echo_say_ena;
    logic [31:0] echo_say_meth;
    logic [31:0] echo_say_v;
    logic        echo_say_rdy;
    logic        heard_ena;
    logic [31:0] heard_meth;
    logic [31:0] heard_v;
    logic        heard_rdy;

    int n_cmp  = 0;
    int n_fail = 0;
    logic exp_q[$];

    always #5 CLK = ~CLK;

    echo_request_arbiter #(.DEPTH(4)) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .req_say__ENA    (say_ena),
        .req_say_meth    (say_meth),
        .req_say_v       (say_v),
        .req_say__RDY    (say_rdy),
        .ind_heard__ENA  (ind_ena),
        .ind_heard_meth  (ind_meth),
        .ind_heard_v     (ind_v),
        .ind_heard__RDY  (ind_rdy),
        .echo_say__ENA   (echo_say_ena),
        .echo_say_meth   (echo_say_meth),
        .echo_say_v      (echo_say_v),
        .echo_say__RDY   (echo_say_rdy),
        .echo_heard__ENA (heard_ena),
        .echo_heard_meth (heard_meth),
        .echo_heard_v    (heard_v),
        .echo_heard__RDY (heard_rdy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST         = 1'b0;
        say_ena      = 2'b00;
        say_meth     = 64'h0;
        say_v        = 64'h0;
        ind_rdy      = 2'b11;
        echo_say_rdy = 1'b1;
        heard_ena    = 1'b1;
        heard_meth   = 32'h0;
        heard_v      = 32'h0;

        // Reset state
        #1;
        chk("rst_heard_rdy", heard_rdy, 1'b0);
        chk("rst_ind_ena", ind_ena, 2'b00);
        chk("rst_say_rdy", say_rdy, 2'b11);
        chk("rst_count", dut.r_count, 3'd0);
        #10;
        nRST      = 1'b1;
        heard_ena = 1'b0;
        ind_rdy   = 2'b00;

        // Contention: both clients every cycle, alternating grant
        say_ena  = 2'b11;
        say_meth = {32'hB0, 32'hA0};
        say_v    = {32'h2, 32'h1};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont_rdy", say_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("cont_ena", echo_say_ena, 1'b1);
            chk("cont_meth", echo_say_meth, (k % 2 == 0) ? 32'hA0 : 32'hB0);
            chk("cont_v", echo_say_v, (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
        end

        // Full: no grant while 4 outstanding
        chk("full_rdy", say_rdy, 2'b00);
        chk("full_ena", echo_say_ena, 1'b0);
        chk("full_count", dut.r_count, 3'd4);
        tick();
        chk("full_rdy2", say_rdy, 2'b00);

        // First pop at full: no push in the same cycle
        heard_ena  = 1'b1;
        ind_rdy    = 2'b11;
        heard_meth = 32'h21;
        heard_v    = 32'h11;
        #1;
        chk("pop_heard_rdy", heard_rdy, 1'b1);
        chk("pop_ind_ena", ind_ena, 2'b01);
        chk("pop_ind_meth", ind_meth, 32'h21);
        chk("pop_ind_v", ind_v, 32'h11);
        chk("pop_say_rdy", say_rdy, 2'b00);
        chk("pop_no_push", echo_say_ena, 1'b0);
        tick();
        heard_ena = 1'b0;
        #1;
        chk("refill_rdy", say_rdy, 2'b01);
        chk("refill_meth", echo_say_meth, 32'hA0);
        tick();

        // Drain: tags now 1,0,1,0
        say_ena   = 2'b00;
        heard_ena = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_ind_ena", ind_ena, (k % 2 == 0) ? 2'b10 : 2'b01);
            tick();
        end
        chk("empty_heard_rdy", heard_rdy, 1'b0);
        chk("empty_ind_ena", ind_ena, 2'b00);
        chk("empty_count", dut.r_count, 3'd0);
        heard_ena = 1'b0;

        // Single client 1 from reset
        nRST = 1'b0;
        #1;
        nRST    = 1'b1;
        say_ena = 2'b10;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("single_rdy", say_rdy, 2'b11);
            chk("single_ena", echo_say_ena, 1'b1);
            chk("single_meth", echo_say_meth, 32'hB0);
            tick();
        end
        say_ena = 2'b00;
        chk("single_count", dut.r_count, 3'd3);

        // Routing: tags 1,0
        nRST = 1'b0;
        #1;
        nRST    = 1'b1;
        say_ena = 2'b10;
        tick();
        say_ena = 2'b01;
        tick();
        say_ena   = 2'b00;
        ind_rdy   = 2'b01;
        heard_ena = 1'b1;
        heard_v   = 32'h55;
        #1;
        chk("route_blk_rdy", heard_rdy, 1'b0);
        chk("route_blk_ena", ind_ena, 2'b00);
        tick();
        chk("route_blk_rdy2", heard_rdy, 1'b0);
        chk("route_count", dut.r_count, 3'd2);
        ind_rdy = 2'b11;
        #1;
        chk("route_rdy", heard_rdy, 1'b1);
        chk("route_ind_ena", ind_ena, 2'b10);
        chk("route_ind_v", ind_v, 32'h55);
        tick();

        // Push to count 2, then simultaneous push/pop
        heard_ena = 1'b0;
        say_ena   = 2'b01;
        tick();
        chk("pp_pre_count", dut.r_count, 3'd2);
        heard_ena = 1'b1;
        #1;
        chk("pp_push", echo_say_ena, 1'b1);
        chk("pp_pop", ind_ena, 2'b01);
        tick();
        chk("pp_count", dut.r_count, 3'd2);
        say_ena   = 2'b00;
        heard_ena = 1'b0;

        // Pointer wrap: 9 fires, 9 pops, scoreboard ordering
        nRST = 1'b0;
        #1;
        nRST    = 1'b1;
        ind_rdy = 2'b11;
        for (int i = 0; i < 11; i++) begin
            logic c;
            logic e;
            c         = (i % 3 == 1);
            say_ena   = (i < 9) ? (c ? 2'b10 : 2'b01) : 2'b00;
            say_meth  = {32'h200 + 32'(i), 32'h100 + 32'(i)};
            heard_ena = (i >= 2);
            #1;
            if (i < 9) begin
                chk("wrap_fire", echo_say_ena, 1'b1);
                chk("wrap_meth", echo_say_meth, c ? 32'h200 + 32'(i) : 32'h100 + 32'(i));
            end
            if (i >= 2) begin
                e = exp_q.pop_front();
                chk("wrap_order", ind_ena, e ? 2'b10 : 2'b01);
            end
            tick();
            if (i < 9) exp_q.push_back(c);
        end
        say_ena   = 2'b00;
        heard_ena = 1'b0;
        chk("wrap_count", dut.r_count, 3'd0);

        // Reset mid-operation with count 3, prio 1
        say_ena = 2'b01;
        tick();
        say_ena = 2'b10;
        tick();
        say_ena = 2'b01;
        tick();
        say_ena = 2'b00;
        chk("mid_count", dut.r_count, 3'd3);
        chk("mid_prio", dut.r_prio, 1'b1);
        #2;
        nRST = 1'b0;
        #1;
        chk("mid_rst_count", dut.r_count, 3'd0);
        chk("mid_rst_prio", dut.r_prio, 1'b0);
        chk("mid_rst_heard_rdy", heard_rdy, 1'b0);
        heard_ena = 1'b1;
        ind_rdy   = 2'b11;
        #1;
        chk("mid_rst_ind_ena", ind_ena, 2'b00);
        tick();
        nRST = 1'b1;
        #1;
        chk("post_rst_heard_rdy", heard_rdy, 1'b0);
        chk("post_rst_ind_ena", ind_ena, 2'b00);
        chk("post_rst_say_rdy", say_rdy, 2'b11);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
